tlb_miss_arb: RTL

- Shares one page-table-walker (PTW) port between the instruction-side and data-side TLB miss paths.
- Latches single-cycle miss pulses and grants them round-robin, one walk at a time.
- Returns the walker's translation to the requesting side as a one-cycle `utlb_entry_t` response.
- Sits between the I/D micro-TLB miss logic and the PTW; applies the data-side store-permission check.

---
 rtl/tlb_miss_arb_pkg.sv | 35 +++
 rtl/tlb_miss_arb_if.sv | 46 ++++
 rtl/rr_arb2.sv | 21 ++
 rtl/tlb_miss_arb.sv | 178 +++++++++++++++++
 4 files changed

// File: rtl/tlb_miss_arb_pkg.sv
// Shared types for the I/D TLB miss arbiter: micro-TLB entry, FSM state, walk-fault rule.
// Optional statistics counters are enabled by defining TLB_ARB_STATS_EN.
package tlb_miss_arb_pkg;

    localparam int M_WIDTH             = 32;
    localparam int LG_PG_SZ            = 12;
    localparam int PPN_W               = M_WIDTH - LG_PG_SZ;
    localparam int TLB_ARB_STALL_LIMIT = 1024;

    typedef struct packed {
        logic             valid;
        logic             r;
        logic             w;
        logic             x;
        logic [PPN_W-1:0] paddr;
    } utlb_entry_t;

    typedef enum logic [1:0] {
        IDLE,
        WALK,
        RESP
    } tlb_arb_state_t;

    // I-side needs execute permission; D-side needs read, plus write for stores.
    function automatic logic walk_fault(logic dside, logic store, logic ptw_fault,
                                        utlb_entry_t e);
        if (dside) return ptw_fault | ~e.r | (store & ~e.w);
        return ptw_fault | ~e.x;
    endfunction

    function automatic logic [31:0] sat_inc32(logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

endpackage

// File: rtl/tlb_miss_arb_if.sv
// Miss-side and walker-side signals of the TLB miss arbiter; master is the arbiter,
// slave is the micro-TLB miss logic plus page-table walker.
interface tlb_miss_arb_if
    import tlb_miss_arb_pkg::*;
#(
    parameter int VPN_W = M_WIDTH - LG_PG_SZ
) ();

    logic             iside_req;
    logic [VPN_W-1:0] iside_vpn;
    logic             dside_req;
    logic [VPN_W-1:0] dside_vpn;
    logic             dside_store;
    logic             flush;

    logic             ptw_req;
    logic [VPN_W-1:0] ptw_vpn;
    logic             ptw_ack;
    utlb_entry_t      ptw_entry;
    logic             ptw_fault;

    logic             iside_rsp_valid;
    logic             dside_rsp_valid;
    utlb_entry_t      tlb_rsp;
    logic             iside_fault;
    logic             dside_fault;
    logic             busy;
    logic             walk_timeout;

    modport master (
        input  iside_req, iside_vpn, dside_req, dside_vpn, dside_store, flush,
        input  ptw_ack, ptw_entry, ptw_fault,
        output ptw_req, ptw_vpn,
        output iside_rsp_valid, dside_rsp_valid, tlb_rsp, iside_fault, dside_fault,
        output busy, walk_timeout
    );

    modport slave (
        output iside_req, iside_vpn, dside_req, dside_vpn, dside_store, flush,
        output ptw_ack, ptw_entry, ptw_fault,
        input  ptw_req, ptw_vpn,
        input  iside_rsp_valid, dside_rsp_valid, tlb_rsp, iside_fault, dside_fault,
        input  busy, walk_timeout
    );

endinterface

// File: rtl/rr_arb2.sv
// Two-way round-robin grant: bit 0 is the I-side, bit 1 the D-side.
// Purely combinational so it can be reused by other two-port arbiters.
module rr_arb2 (
    input  logic [1:0] pend_i,
    input  logic       last_dside_i,
    output logic       gnt_valid_o,
    output logic       gnt_dside_o
);

    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        gnt_valid_o = |pend_i;
        gnt_dside_o = 1'b0;
        case (pend_i)
            2'b10:   gnt_dside_o = 1'b1;
            2'b11:   gnt_dside_o = ~last_dside_i;
            default: gnt_dside_o = 1'b0;
        endcase
    end

endmodule

// File: rtl/tlb_miss_arb.sv
// Shares one page-table-walker port between I-side and D-side micro-TLB misses.
// Defining TLB_ARB_STATS_EN adds saturating walk statistics output ports.
module tlb_miss_arb
    import tlb_miss_arb_pkg::*;
#(
    parameter int VPN_W       = M_WIDTH - LG_PG_SZ,
    parameter int STALL_LIMIT = TLB_ARB_STALL_LIMIT
) (
    input  logic           clk,
    input  logic           reset_n,
    tlb_miss_arb_if.master bus
`ifdef TLB_ARB_STATS_EN
    ,
    output logic [31:0]    iside_walks,
    output logic [31:0]    dside_walks,
    output logic [31:0]    walk_cycles,
    output logic [31:0]    squashed_walks
`endif
);

    localparam int                CNT_W   = $clog2(STALL_LIMIT + 1);
    localparam logic [CNT_W-1:0]  CNT_MAX = CNT_W'(STALL_LIMIT);

    tlb_arb_state_t   state_q;
    logic             pend_i_q, pend_d_q;
    logic [VPN_W-1:0] vpn_i_q, vpn_d_q;
    logic             store_q;
    logic             last_dside_q;
    logic             gnt_dside_q, gnt_store_q;
    logic             squash_q;
    logic [CNT_W-1:0] cnt_q;
    logic             ptw_req_q;
    logic [VPN_W-1:0] ptw_vpn_q;
    logic             rsp_i_q, rsp_d_q;
    utlb_entry_t      tlb_rsp_q;
    logic             fault_i_q, fault_d_q;
    logic             busy_q, busy_d;
    logic             timeout_q;

    logic             pend_i_cur, pend_d_cur;
    logic [VPN_W-1:0] vpn_i_cur, vpn_d_cur;
    logic             store_cur;
    logic             gnt_valid, gnt_dside, grant_fire;
    logic             squash_cur, fault_cur;
    utlb_entry_t      entry_cur;

    rr_arb2 u_rr_arb2 (
        .pend_i      ({pend_d_cur, pend_i_cur}),
        .last_dside_i(last_dside_q),
        .gnt_valid_o (gnt_valid),
        .gnt_dside_o (gnt_dside)
    );

    // Same-cycle requests take part in the grant, so the walk starts the next cycle.
    always_comb begin
        pend_i_cur = pend_i_q | bus.iside_req;
        pend_d_cur = pend_d_q | bus.dside_req;
        vpn_i_cur  = bus.iside_req ? bus.iside_vpn : vpn_i_q;
        vpn_d_cur  = bus.dside_req ? bus.dside_vpn : vpn_d_q;
        store_cur  = bus.dside_req ? bus.dside_store : store_q;
        grant_fire = (state_q == IDLE) & ~bus.flush & gnt_valid;
        squash_cur = squash_q | bus.flush;
        fault_cur  = walk_fault(gnt_dside_q, gnt_store_q, bus.ptw_fault, bus.ptw_entry);
        entry_cur  = bus.ptw_entry;
        if (fault_cur) entry_cur.valid = 1'b0;
        busy_d     = (state_q == WALK) | (~bus.flush & (pend_i_cur | pend_d_cur));
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q      <= IDLE;
            pend_i_q     <= 1'b0;
            pend_d_q     <= 1'b0;
            vpn_i_q      <= '0;
            vpn_d_q      <= '0;
            store_q      <= 1'b0;
            last_dside_q <= 1'b1;
            gnt_dside_q  <= 1'b0;
            gnt_store_q  <= 1'b0;
            squash_q     <= 1'b0;
            cnt_q        <= '0;
            ptw_req_q    <= 1'b0;
            ptw_vpn_q    <= '0;
            rsp_i_q      <= 1'b0;
            rsp_d_q      <= 1'b0;
            tlb_rsp_q    <= '0;
            fault_i_q    <= 1'b0;
            fault_d_q    <= 1'b0;
            busy_q       <= 1'b0;
            timeout_q    <= 1'b0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so later lines see old values.
            rsp_i_q   <= 1'b0;
            rsp_d_q   <= 1'b0;
            fault_i_q <= 1'b0;
            fault_d_q <= 1'b0;
            busy_q    <= busy_d;
            pend_i_q  <= pend_i_cur & ~bus.flush;
            pend_d_q  <= pend_d_cur & ~bus.flush;
            if (bus.iside_req) vpn_i_q <= bus.iside_vpn;
            if (bus.dside_req) begin
                vpn_d_q <= bus.dside_vpn;
                store_q <= bus.dside_store;
            end

            case (state_q)
                IDLE: begin
                    if (grant_fire) begin
                        state_q     <= WALK;
                        ptw_req_q   <= 1'b1;
                        ptw_vpn_q   <= gnt_dside ? vpn_d_cur : vpn_i_cur;
                        gnt_dside_q <= gnt_dside;
                        gnt_store_q <= store_cur;
                        cnt_q       <= '0;
                        if (gnt_dside) pend_d_q <= 1'b0;
                        else           pend_i_q <= 1'b0;
                        if (pend_i_cur && pend_d_cur) last_dside_q <= gnt_dside;
                    end
                end
                WALK: begin
                    if (bus.flush) squash_q <= 1'b1;
                    if (bus.ptw_ack) begin
                        state_q   <= RESP;
                        ptw_req_q <= 1'b0;
                        rsp_i_q   <= ~gnt_dside_q & ~squash_cur;
                        rsp_d_q   <= gnt_dside_q & ~squash_cur;
                        fault_i_q <= ~gnt_dside_q & fault_cur;
                        fault_d_q <= gnt_dside_q & fault_cur;
                        tlb_rsp_q <= entry_cur;
                    end else if (cnt_q != CNT_MAX) begin
                        cnt_q <= cnt_q + 1'b1;
                        if (cnt_q == CNT_MAX - 1'b1) timeout_q <= 1'b1;
                    end
                end
                RESP: begin
                    squash_q <= 1'b0;
                    state_q  <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.ptw_req         = ptw_req_q;
    assign bus.ptw_vpn         = ptw_vpn_q;
    assign bus.iside_rsp_valid = rsp_i_q;
    assign bus.dside_rsp_valid = rsp_d_q;
    assign bus.tlb_rsp         = tlb_rsp_q;
    assign bus.iside_fault     = fault_i_q;
    assign bus.dside_fault     = fault_d_q;
    assign bus.busy            = busy_q;
    assign bus.walk_timeout    = timeout_q;

`ifdef TLB_ARB_STATS_EN
    logic [31:0] iside_walks_q, dside_walks_q, walk_cycles_q, squashed_walks_q;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            iside_walks_q    <= '0;
            dside_walks_q    <= '0;
            walk_cycles_q    <= '0;
            squashed_walks_q <= '0;
        end else begin
            if (grant_fire && !gnt_dside) iside_walks_q <= sat_inc32(iside_walks_q);
            if (grant_fire && gnt_dside)  dside_walks_q <= sat_inc32(dside_walks_q);
            if (state_q == WALK)          walk_cycles_q <= sat_inc32(walk_cycles_q);
            if (state_q == WALK && bus.ptw_ack && squash_cur)
                squashed_walks_q <= sat_inc32(squashed_walks_q);
        end
    end

    assign iside_walks    = iside_walks_q;
    assign dside_walks    = dside_walks_q;
    assign walk_cycles    = walk_cycles_q;
    assign squashed_walks = squashed_walks_q;
`endif

endmodule
